div_result_bcd: RTL and testbench

DIV_RESULT_BCD -- requirements
Module: div_result_bcd

---
 rtl/div_result_bcd.sv | 155 +++++++++++++++
 tb/tb_div_result_bcd.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd.sv
// Purpose : binary-to-BCD converter for the divider quotient (double-dabble, one bit per clock).
// Latency : valid rises 16 clocks after the done_in rising edge that starts a conversion.
// Backpr. : a result is held with valid=1 until ack; a new done_in edge overwrites an unacknowledged result.
//
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   done_in   - divider done level; only its rising edge starts a conversion
//   quotient  - 16-bit unsigned value to convert, sampled on the done_in rising edge
//   ack       - consumer has taken bcd (only meaningful while a result is held)
//   bcd       - five BCD digits, [19:16] ten-thousands ... [3:0] units
//   valid     - bcd holds a new, unacknowledged result
//   busy      - conversion in progress
//
// Compile-time option: DIV_BCD_BLANK_EN - leading zero digits above the most
// significant nonzero digit are written as 4'hF; the units digit is never blanked.
module div_result_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_in,
    input  logic [15:0] quotient,
    input  logic        ack,
    output logic [19:0] bcd,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        done_d_q;
    logic [15:0] shift_q, shift_d;
    logic [19:0] scratch_q, scratch_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic        capture;
    logic [19:0] adj;
    logic [19:0] dabble_scratch;
    logic [15:0] dabble_shift;

`ifdef DIV_BCD_BLANK_EN
    // Replace leading zero digits with the blank code, scanning from the top
    // digit down; digit 0 is excluded so zero still shows as a single 0.
    function automatic logic [19:0] fmt_bcd(input logic [19:0] v);
        logic [19:0] r;
        logic        lead;
        r    = v;
        lead = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            if (lead && (v[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`else
    function automatic logic [19:0] fmt_bcd(input logic [19:0] v);
        return v;
    endfunction
`endif

    // Only the rising edge of the done level counts; done_d_q resets high so a
    // level already present at reset release is not mistaken for an edge.
    assign capture = done_in & ~done_d_q;

    // One double-dabble step: add-3 correction on every digit >= 5, then shift
    // the combined {scratch, shift} register left by one bit.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        dabble_scratch = {adj[18:0], shift_q[15]};
        dabble_shift   = {shift_q[14:0], 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        valid_d   = valid_q;

        case (state_q)
            IDLE, HOLD: begin
                // A new edge wins over a simultaneous ack and discards any held result.
                if (capture) begin
                    shift_d   = quotient;
                    scratch_d = 20'd0;
                    cnt_d     = 5'd0;
                    valid_d   = 1'b0;
                    state_d   = CONV;
                end else if ((state_q == HOLD) && ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            CONV: begin
                scratch_d = dabble_scratch;
                shift_d   = dabble_shift;
                cnt_d     = cnt_q + 5'd1;
                // Sixteenth step: the post-shift scratch is the finished result.
                if (cnt_q == 5'd15) begin
                    bcd_d   = fmt_bcd(dabble_scratch);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CONV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            done_d_q  <= 1'b1;
            shift_q   <= 16'd0;
            scratch_q <= 20'd0;
            cnt_q     <= 5'd0;
            bcd_q     <= 20'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_d_q  <= done_in;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bcd   = bcd_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Purpose : directed bench for div_result_bcd with a queue-based result scoreboard.
// Latency : expects valid 16 clocks after each accepted done_in edge.
// Backpr. : drives ack explicitly; the monitor pops one expectation per valid rising edge.
module tb_div_result_bcd;

    logic        clk;
    logic        rst;
    logic        done_in;
    logic [15:0] quotient;
    logic        ack;
    logic [19:0] bcd;
    logic        valid;
    logic        busy;

`ifdef DIV_BCD_BLANK_EN
    localparam logic [19:0] EXP_0     = 20'hFFFF0;
    localparam logic [19:0] EXP_42    = 20'hFFF42;
    localparam logic [19:0] EXP_500   = 20'hFF500;
    localparam logic [19:0] EXP_9876  = 20'hF9876;
`else
    localparam logic [19:0] EXP_0     = 20'h00000;
    localparam logic [19:0] EXP_42    = 20'h00042;
    localparam logic [19:0] EXP_500   = 20'h00500;
    localparam logic [19:0] EXP_9876  = 20'h09876;
`endif
    localparam logic [19:0] EXP_12345 = 20'h12345;
    localparam logic [19:0] EXP_65535 = 20'h65535;

    int checks   = 0;
    int failures = 0;
    int results  = 0;
    logic        valid_seen = 1'b0;
    logic [19:0] exp_q[$];

    div_result_bcd dut (
        .clk      (clk),
        .rst      (rst),
        .done_in  (done_in),
        .quotient (quotient),
        .ack      (ack),
        .bcd      (bcd),
        .valid    (valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every valid rising edge must match the oldest expectation.
    always @(negedge clk) begin
        logic [19:0] e;
        if (!rst && valid && !valid_seen) begin
            results++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h required=none", bcd);
            end else begin
                e = exp_q.pop_front();
                chk("scoreboard_bcd", {12'd0, bcd}, {12'd0, e});
            end
        end
        valid_seen = valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Starts a conversion (done_in high before edge 0, held for 'hold' edges,
    // optionally re-raised at edge e2) and measures timing over 24 edges.
    task automatic run_conv(input logic [15:0] q, input int hold, input int e2,
                            input logic ack0, input logic [19:0] exp_bcd,
                            output int valid_at, output int busy_cnt, output int bcd_changes);
        logic [19:0] b0;
        quotient = q;
        done_in  = 1'b1;
        ack      = ack0;
        exp_q.push_back(exp_bcd);
        b0          = bcd;
        valid_at    = -1;
        busy_cnt    = 0;
        bcd_changes = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            ack = 1'b0;
            if (busy) busy_cnt++;
            if (valid && valid_at < 0) valid_at = k;
            if (k < 16 && bcd !== b0) bcd_changes++;
            done_in = ((k + 1) < hold) || ((k + 1) == e2);
            if ((k + 1) == e2) quotient = 16'd1111;
        end
        done_in = 1'b0;
    endtask

    initial begin
        int va, bc, ch, r0;
        rst      = 1'b1;
        done_in  = 1'b0;
        quotient = 16'd0;
        ack      = 1'b0;
        repeat (3) tick();
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy",  {31'd0, busy},  32'd0);
        chk("reset_bcd",   {12'd0, bcd},   32'd0);
        rst = 1'b0;
        tick();
        chk("idle_valid", {31'd0, valid}, 32'd0);

        // 12345 with done_in held 10 cycles: one conversion, 16-clock latency.
        r0 = results;
        run_conv(16'd12345, 10, -1, 1'b0, EXP_12345, va, bc, ch);
        chk("t12345_valid_at", va, 32'd16);
        chk("t12345_busy_cnt", bc, 32'd16);
        chk("t12345_bcd_stable", ch, 32'd0);
        repeat (4) tick();
        chk("t12345_one_conv", results - r0, 32'd1);
        chk("t12345_bcd", {12'd0, bcd}, {12'd0, EXP_12345});

        // ack in HOLD clears valid and keeps bcd; ack in IDLE does nothing.
        do_ack();
        chk("ack_hold_valid", {31'd0, valid}, 32'd0);
        chk("ack_hold_bcd",   {12'd0, bcd},   {12'd0, EXP_12345});
        do_ack();
        chk("ack_idle_valid", {31'd0, valid}, 32'd0);
        chk("ack_idle_busy",  {31'd0, busy},  32'd0);
        chk("ack_idle_bcd",   {12'd0, bcd},   {12'd0, EXP_12345});

        // Boundary values.
        run_conv(16'd0, 1, -1, 1'b0, EXP_0, va, bc, ch);
        chk("t0_valid_at", va, 32'd16);
        do_ack();
        run_conv(16'd65535, 1, -1, 1'b0, EXP_65535, va, bc, ch);
        chk("t65535_valid_at", va, 32'd16);
        chk("t65535_bcd", {12'd0, bcd}, {12'd0, EXP_65535});

        // Still in HOLD: capture edge and ack together; capture wins.
        run_conv(16'd42, 3, -1, 1'b1, EXP_42, va, bc, ch);
        chk("t42_valid_at", va, 32'd16);
        chk("t42_busy_cnt", bc, 32'd16);
        chk("t42_old_bcd_stable", ch, 32'd0);
        do_ack();

        // Second done_in edge at CONV cycle 5 must be ignored.
        r0 = results;
        run_conv(16'd9876, 2, 5, 1'b0, EXP_9876, va, bc, ch);
        chk("t9876_valid_at", va, 32'd16);
        chk("t9876_busy_cnt", bc, 32'd16);
        repeat (4) tick();
        chk("t9876_one_conv", results - r0, 32'd1);
        do_ack();

        // Reset at CONV cycle 8 with done_in held high across it.
        quotient = 16'd500;
        done_in  = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",  {31'd0, busy},  32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_bcd",   {12'd0, bcd},   32'd0);
        bc = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (busy) bc++;
        end
        chk("held_done_no_capture", bc, 32'd0);
        done_in = 1'b0;
        tick();
        run_conv(16'd500, 2, -1, 1'b0, EXP_500, va, bc, ch);
        chk("t500_valid_at", va, 32'd16);
        do_ack();

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
